// File: rtl/pix_sum_feeder.sv
// Accumulates pixel groups into {sum, length} records and feeds them to a
// downstream divider through a 2-entry FIFO whose head register drives the outputs.
module pix_sum_feeder (
    input  logic        clk_sys,
    input  logic        reset_sys,
    input  logic        reset_sync,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic [7:0]  frame_len,
    input  logic        div_in_valid,
    output logic [15:0] divident,
    output logic [7:0]  divisor,
    output logic        feed_valid,
    output logic        full,
    output logic        overflow,
    output logic        underrun
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t      state_reg;
    logic [15:0] sum_reg;
    logic [7:0]  cnt_reg;
    logic [7:0]  len_reg;
    logic [15:0] head_sum_reg, tail_sum_reg;
    logic [7:0]  head_len_reg, tail_len_reg;
    logic [1:0]  count_reg;
    logic        overflow_reg, underrun_reg;

    logic [7:0]  len_eff;
    logic [15:0] sum_acc;
    logic [7:0]  cnt_acc;
    logic        push, pop;
    logic [15:0] push_sum;
    logic [7:0]  push_len;

    assign len_eff = (frame_len == 8'd0) ? 8'd1 : frame_len;
    assign sum_acc = sum_reg + {8'd0, pix_data};
    assign cnt_acc = cnt_reg + 8'd1;
    assign pop     = div_in_valid && (count_reg != 2'd0);

    // A group completes either on its first pixel (length 1) or when cnt reaches len.
    always_comb begin
        push     = 1'b0;
        push_sum = sum_acc;
        push_len = len_reg;
        if (pix_valid) begin
            if (state_reg == IDLE) begin
                push     = (len_eff == 8'd1);
                push_sum = {8'd0, pix_data};
                push_len = len_eff;
            end else begin
                push = (cnt_acc == len_reg);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            state_reg    <= IDLE;
            sum_reg      <= 16'd0;
            cnt_reg      <= 8'd0;
            len_reg      <= 8'd0;
            head_sum_reg <= 16'd0;
            head_len_reg <= 8'd0;
            tail_sum_reg <= 16'd0;
            tail_len_reg <= 8'd0;
            count_reg    <= 2'd0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (reset_sync) begin
            state_reg    <= IDLE;
            sum_reg      <= 16'd0;
            cnt_reg      <= 8'd0;
            len_reg      <= 8'd0;
            head_sum_reg <= 16'd0;
            head_len_reg <= 8'd0;
            tail_sum_reg <= 16'd0;
            tail_len_reg <= 8'd0;
            count_reg    <= 2'd0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            overflow_reg <= push && (count_reg == 2'd2) && !pop;
            underrun_reg <= div_in_valid && (count_reg == 2'd0);

            if (pix_valid) begin
                if (state_reg == IDLE) begin
                    len_reg   <= len_eff;
                    sum_reg   <= {8'd0, pix_data};
                    cnt_reg   <= 8'd1;
                    state_reg <= (len_eff == 8'd1) ? IDLE : ACC;
                end else begin
                    sum_reg   <= sum_acc;
                    cnt_reg   <= cnt_acc;
                    state_reg <= push ? IDLE : ACC;
                end
            end

            // Head register holds its last value when the FIFO drains.
            case (count_reg)
                2'd0: begin
                    if (push) begin
                        head_sum_reg <= push_sum;
                        head_len_reg <= push_len;
                        count_reg    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_sum_reg <= push_sum;
                        head_len_reg <= push_len;
                    end else if (push) begin
                        tail_sum_reg <= push_sum;
                        tail_len_reg <= push_len;
                        count_reg    <= 2'd2;
                    end else if (pop) begin
                        count_reg <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_sum_reg <= tail_sum_reg;
                        head_len_reg <= tail_len_reg;
                        if (push) begin
                            tail_sum_reg <= push_sum;
                            tail_len_reg <= push_len;
                        end else begin
                            count_reg <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign divident   = head_sum_reg;
    assign divisor    = head_len_reg;
    assign feed_valid = (count_reg != 2'd0);
    assign full       = (count_reg == 2'd2);
    assign overflow   = overflow_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_pix_sum_feeder.sv
// Scoreboard bench for pix_sum_feeder: expected {sum, len} records are queued
// as groups are driven and compared against the FIFO head as they are popped.
module tb_pix_sum_feeder;

    logic        clk_sys = 1'b0;
    logic        reset_sys, reset_sync, pix_valid, div_in_valid;
    logic [7:0]  pix_data, frame_len;
    logic [15:0] divident;
    logic [7:0]  divisor;
    logic        feed_valid, full, overflow, underrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] exp_q[$];
    logic [23:0] last_head;

    pix_sum_feeder dut (
        .clk_sys      (clk_sys),
        .reset_sys    (reset_sys),
        .reset_sync   (reset_sync),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .frame_len    (frame_len),
        .div_in_valid (div_in_valid),
        .divident     (divident),
        .divisor      (divisor),
        .feed_valid   (feed_valid),
        .full         (full),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_group(input int n, input int flen, input int first, input int step,
                             input int gap, input bit pop_last);
        int s;
        int exp_len;
        bit ovf_exp;
        s = 0;
        exp_len = (flen == 0) ? 1 : flen;
        frame_len = 8'(flen);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(first + i * step);
            s += first + i * step;
            if (i == n - 1 && pop_last) begin
                chk("pl_head_sum", 32'(divident), 32'(exp_q[0][23:8]));
                chk("pl_head_len", 32'(divisor), 32'(exp_q[0][7:0]));
                div_in_valid = 1'b1;
            end
            tick();
            pix_valid    = 1'b0;
            div_in_valid = 1'b0;
            if (i == n - 1) begin
                ovf_exp = (exp_q.size() == 2) && !pop_last;
                if (pop_last) last_head = exp_q.pop_front();
                if (!ovf_exp) exp_q.push_back({16'(s), 8'(exp_len)});
                chk("overflow", 32'(overflow), 32'(ovf_exp));
                chk("feed_valid", 32'(feed_valid), 32'(exp_q.size() != 0));
                chk("full", 32'(full), 32'(exp_q.size() == 2));
            end else begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    task automatic pop_one();
        div_in_valid = 1'b1;
        if (exp_q.size() != 0) begin
            chk("head_sum", 32'(divident), 32'(exp_q[0][23:8]));
            chk("head_len", 32'(divisor), 32'(exp_q[0][7:0]));
            tick();
            div_in_valid = 1'b0;
            last_head = exp_q.pop_front();
            chk("no_underrun", 32'(underrun), 32'd0);
        end else begin
            tick();
            div_in_valid = 1'b0;
            chk("underrun", 32'(underrun), 32'd1);
            chk("hold_sum", 32'(divident), 32'(last_head[23:8]));
            chk("hold_len", 32'(divisor), 32'(last_head[7:0]));
        end
        chk("feed_after_pop", 32'(feed_valid), 32'(exp_q.size() != 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_sys = 1'b1; reset_sync = 1'b0; pix_valid = 1'b0; div_in_valid = 1'b0;
        pix_data = 8'd0; frame_len = 8'd0; last_head = 24'd0;
        #2;
        chk("rst_async_feed", 32'(feed_valid), 32'd0);
        chk("rst_divident", 32'(divident), 32'd0);
        chk("rst_divisor", 32'(divisor), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        tick(); tick();
        reset_sys = 1'b0;
        tick();

        // 10..50, frame_len 5
        run_group(5, 5, 10, 10, 0, 0);
        pop_one();
        // frame_len 0 treated as 1
        run_group(1, 0, 77, 0, 0, 0);
        pop_one();
        // largest possible sum
        run_group(255, 255, 255, 0, 1, 0);
        pop_one();

        // three 2-pixel groups: 3, 7, 11 (third dropped)
        run_group(2, 2, 1, 1, 0, 0);
        run_group(2, 2, 3, 1, 0, 0);
        run_group(2, 2, 5, 1, 0, 0);
        tick();
        chk("overflow_pulse_end", 32'(overflow), 32'd0);
        pop_one();
        pop_one();

        // underrun on empty FIFO
        pop_one();
        tick();
        chk("underrun_pulse_end", 32'(underrun), 32'd0);

        // push and pop together while full
        run_group(2, 2, 2, 2, 1, 0);
        run_group(3, 3, 4, 1, 0, 0);
        run_group(2, 2, 20, 5, 2, 1);
        pop_one();
        pop_one();

        // reset_sync mid-group with a queued entry, colliding with pixel and pop
        run_group(1, 1, 9, 0, 0, 0);
        frame_len = 8'd5;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_data = 8'd1; tick();
        end
        reset_sync = 1'b1; div_in_valid = 1'b1; pix_valid = 1'b1;
        tick();
        reset_sync = 1'b0; div_in_valid = 1'b0; pix_valid = 1'b0;
        exp_q.delete();
        last_head = 24'd0;
        chk("sync_feed", 32'(feed_valid), 32'd0);
        chk("sync_divident", 32'(divident), 32'd0);
        chk("sync_divisor", 32'(divisor), 32'd0);
        chk("sync_underrun", 32'(underrun), 32'd0);
        run_group(5, 5, 1, 0, 0, 0);
        pop_one();

        // asynchronous reset between edges
        run_group(2, 2, 30, 1, 0, 0);
        #1 reset_sys = 1'b1;
        #1;
        chk("async_mid_feed", 32'(feed_valid), 32'd0);
        chk("async_mid_divident", 32'(divident), 32'd0);
        reset_sys = 1'b0;
        exp_q.delete();
        last_head = 24'd0;
        tick();
        run_group(4, 4, 6, 3, 0, 0);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pix_sum_feeder.md
PIX_SUM_FEEDER -- requirements
Module: pix_sum_feeder

Interface
REQ-001 SHALL have port clk_sys, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_sys, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port reset_sync, input, 1 bit: synchronous active-high clear, same effect as reset_sys at the next clock edge.
REQ-004 SHALL have port pix_valid, input, 1 bit: pix_data carries a valid pixel this cycle.
REQ-005 SHALL have port pix_data, input, 8 bits: unsigned pixel value.
REQ-006 SHALL have port frame_len, input, 8 bits: pixels per group; sampled only on the first pixel of each group.
REQ-007 SHALL have port div_in_valid, input, 1 bit: the downstream divider samples divident/divisor this cycle.
REQ-008 SHALL have port divident, output, 16 bits: group sum at the FIFO head.
REQ-009 SHALL have port divisor, output, 8 bits: group length at the FIFO head.
REQ-010 SHALL have port feed_valid, output, 1 bit: FIFO not empty, so divident/divisor are valid.
REQ-011 SHALL have port full, output, 1 bit: FIFO holds 2 entries.
REQ-012 SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed group is dropped.
REQ-013 SHALL have port underrun, output, 1 bit: one-cycle pulse when div_in_valid arrives while the FIFO is empty.

Function
REQ-014 SHALL implement a two-state accumulator FSM: IDLE (no group open) and ACC (group open).
REQ-015 In IDLE with pix_valid, SHALL latch len = frame_len (0 replaced by 1), set sum = pix_data and cnt = 1, then go to ACC; if len == 1, the group completes in this same cycle.
REQ-016 In ACC with pix_valid, SHALL set sum = sum + pix_data (16-bit) and cnt = cnt + 1.
REQ-017 When cnt reaches len, the group SHALL complete, push {sum incl. current pixel, len} in the same edge, and return to IDLE.
REQ-018 Cycles with pix_valid low SHALL leave sum, cnt and state unchanged, in any state.
REQ-019 The sum SHALL never wrap: the maximum value 255*255 = 65025 fits in 16 bits, and no saturation logic is needed.
REQ-020 SHALL buffer groups in a 2-entry FIFO of {16-bit sum, 8-bit len} with in-order output.
REQ-021 divident/divisor SHALL be driven from registered FIFO head storage (no combinational path from pix_data).
REQ-022 Push latency: a group whose last pixel is accepted at edge N into an empty FIFO SHALL give feed_valid = 1 and head valid from cycle N+1.
REQ-023 div_in_valid with feed_valid = 1 SHALL pop the head at that edge; the next entry, if any, is presented the following cycle.
REQ-024 div_in_valid with the FIFO empty SHALL pulse underrun for one cycle and leave divident/divisor holding their last values.
REQ-025 A group completion with the FIFO full and no simultaneous pop SHALL drop the new group, pulse overflow for one cycle and leave the FIFO contents unchanged.
REQ-026 A simultaneous push and pop SHALL always accept the push, including when the FIFO is full, so occupancy is unchanged.
REQ-027 A simultaneous push and pop into an empty FIFO is impossible, because a pop requires feed_valid.

Reset
REQ-028 On reset_sys (asynchronous) or reset_sync (at the clock edge), the block SHALL force: state IDLE, sum 0, cnt 0, len 0, FIFO empty, divident 0, divisor 0, feed_valid 0, full 0, overflow 0, underrun 0.
REQ-029 Reset mid-group SHALL discard the partial group; the first pix_valid after release starts a new group.
REQ-030 reset_sync SHALL take priority over pix_valid and div_in_valid in the same cycle.

Verification
REQ-031 frame_len = 5; pixels 10, 20, 30, 40, 50 on consecutive cycles -> cycle after the 5th pixel: divident = 150, divisor = 5, feed_valid = 1.
REQ-032 frame_len = 255; 255 pixels of value 255 with gaps -> divident = 65025, divisor = 255.
REQ-033 frame_len = 0; single pixel 77 -> divident = 77, divisor = 1 one cycle later.
REQ-034 Three 2-pixel groups (sums 3, 7, 11), no div_in_valid -> full = 1 after the second group; overflow pulses on the third; two pops then return 3 and 7 in order, after which feed_valid = 0.
REQ-035 div_in_valid with the FIFO empty -> underrun = 1 for one cycle, divident/divisor unchanged; simultaneous pop and push with the FIFO full -> no overflow, full stays 1.
REQ-036 reset_sync asserted after 3 of 5 pixels -> FIFO empty; a fresh 5-pixel group of 1s yields divident = 5, divisor = 5.
